// File: rtl/interrupt_sequencer_pkg.sv
// Shared types and constants for the interrupt entry sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package interrupt_sequencer_pkg;

  // One state per bus cycle of the interrupt entry sequence.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PUSH_PCH = 3'd1,
    ST_PUSH_PCL = 3'd2,
    ST_PUSH_P   = 3'd3,
    ST_VEC_LO   = 3'd4,
    ST_VEC_HI   = 3'd5,
    ST_LOAD     = 3'd6
  } state_e;

  // Source of the accepted sequence; selects the vector and the pushed B bit.
  typedef enum logic [1:0] {
    KIND_IRQ = 2'd0,
    KIND_BRK = 2'd1,
    KIND_NMI = 2'd2
  } kind_e;

  localparam logic [15:0] VEC_NMI     = 16'hFFFA;
  localparam logic [15:0] VEC_IRQ_BRK = 16'hFFFE;
  localparam logic [7:0]  STACK_PAGE  = 8'h01;

  localparam int unsigned PSR_I = 2;
  localparam int unsigned PSR_B = 4;
  localparam int unsigned PSR_U = 5;

  function automatic logic [15:0] vector_of(input kind_e k);
    return (k == KIND_NMI) ? VEC_NMI : VEC_IRQ_BRK;
  endfunction

endpackage

// File: rtl/interrupt_sequencer_nmi_edge_latch.sv
// NMI rising-edge detector with a pending latch held until the sequencer accepts it.
// Latency: edge seen in cycle k -> o_pend high from cycle k+1.
// Backpressure: none; the latch simply holds until i_accept.
// Ports: clk, rst (async, active-high), i_nmi (raw NMI level),
//        i_accept (NMI sequence accepted this cycle), o_pend (NMI pending).
module nmi_edge_latch (
  input  logic clk,
  input  logic rst,
  input  logic i_nmi,
  input  logic i_accept,
  output logic o_pend
);

  logic nmi_prev_q, nmi_prev_d;
  logic pend_q, pend_d;

  // A new edge wins over the accept clear, so an edge landing in the
  // acceptance cycle queues a second NMI sequence.
  always_comb begin
    nmi_prev_d = i_nmi;
    pend_d     = (i_nmi & ~nmi_prev_q) | (pend_q & ~i_accept);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nmi_prev_q <= 1'b0;
      pend_q     <= 1'b0;
    end else begin
      nmi_prev_q <= nmi_prev_d;
      pend_q     <= pend_d;
    end
  end

  assign o_pend = pend_q;

endmodule

// File: rtl/interrupt_sequencer.sv
// 6502-style interrupt entry sequencer: pushes PC and P, fetches the vector, loads PC.
// Latency: accepted in cycle N, o_pc_load pulses in cycle N+6.
// Backpressure: o_busy stalls the core; IRQ/BRK ignored while busy, NMI edges are latched.
// Ports: clk, rst (async, active-high); core side i_boundary, i_irq, i_nmi, i_brk,
//        i_psr, i_pc, i_sp; memory i_rdata, o_addr, o_wdata, o_we; status controls
//        o_sp_dec, o_set_i, o_i_intr, o_set_b, o_b_brk; PC load o_pc_load, o_pc; o_busy.
module interrupt_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_boundary,
  input  logic        i_irq,
  input  logic        i_nmi,
  input  logic        i_brk,
  input  logic [7:0]  i_psr,
  input  logic [15:0] i_pc,
  input  logic [7:0]  i_sp,
  input  logic [7:0]  i_rdata,
  output logic [15:0] o_addr,
  output logic [7:0]  o_wdata,
  output logic        o_we,
  output logic        o_sp_dec,
  output logic        o_set_i,
  output logic        o_i_intr,
  output logic        o_set_b,
  output logic        o_b_brk,
  output logic        o_pc_load,
  output logic [15:0] o_pc,
  output logic        o_busy
);
  import interrupt_sequencer_pkg::*;

  state_e      state_q, state_d;
  kind_e       kind_q, kind_d;
  logic [7:0]  vec_lo_q, vec_lo_d;
  logic        nmi_pend;
  logic        accept_nmi;
  logic [15:0] vec_base;
  logic [7:0]  p_push;

  nmi_edge_latch u_nmi (
    .clk      (clk),
    .rst      (rst),
    .i_nmi    (i_nmi),
    .i_accept (accept_nmi),
    .o_pend   (nmi_pend)
  );

  // Next-state: acceptance priority NMI > BRK > unmasked IRQ, only at a boundary.
  always_comb begin
    state_d    = state_q;
    kind_d     = kind_q;
    vec_lo_d   = vec_lo_q;
    accept_nmi = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_boundary) begin
          if (nmi_pend) begin
            kind_d     = KIND_NMI;
            accept_nmi = 1'b1;
            state_d    = ST_PUSH_PCH;
          end else if (i_brk) begin
            kind_d  = KIND_BRK;
            state_d = ST_PUSH_PCH;
          end else if (i_irq && !i_psr[PSR_I]) begin
            kind_d  = KIND_IRQ;
            state_d = ST_PUSH_PCH;
          end
        end
      end
      ST_PUSH_PCH: state_d = ST_PUSH_PCL;
      ST_PUSH_PCL: state_d = ST_PUSH_P;
      ST_PUSH_P:   state_d = ST_VEC_LO;
      ST_VEC_LO:   state_d = ST_VEC_HI;
      ST_VEC_HI: begin
        // Read data for the VEC_LO address arrives this cycle.
        vec_lo_d = i_rdata;
        state_d  = ST_LOAD;
      end
      ST_LOAD:     state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      kind_q   <= KIND_IRQ;
      vec_lo_q <= 8'h00;
    end else begin
      state_q  <= state_d;
      kind_q   <= kind_d;
      vec_lo_q <= vec_lo_d;
    end
  end

  // Output decode from the registered state; data fields pass the core's
  // current values through so the push tracks the live stack pointer.
  always_comb begin
    o_addr    = 16'h0000;
    o_wdata   = 8'h00;
    o_we      = 1'b0;
    o_sp_dec  = 1'b0;
    o_set_i   = 1'b0;
    o_i_intr  = 1'b0;
    o_set_b   = 1'b0;
    o_b_brk   = 1'b0;
    o_pc_load = 1'b0;
    o_pc      = 16'h0000;
    o_busy    = 1'b0;
    vec_base  = vector_of(kind_q);
    p_push         = i_psr;
    p_push[PSR_U]  = 1'b1;
    p_push[PSR_B]  = (kind_q == KIND_BRK);
    case (state_q)
      ST_PUSH_PCH: begin
        o_busy   = 1'b1;
        o_addr   = {STACK_PAGE, i_sp};
        o_wdata  = i_pc[15:8];
        o_we     = 1'b1;
        o_sp_dec = 1'b1;
      end
      ST_PUSH_PCL: begin
        o_busy   = 1'b1;
        o_addr   = {STACK_PAGE, i_sp};
        o_wdata  = i_pc[7:0];
        o_we     = 1'b1;
        o_sp_dec = 1'b1;
      end
      ST_PUSH_P: begin
        o_busy   = 1'b1;
        o_addr   = {STACK_PAGE, i_sp};
        o_wdata  = p_push;
        o_we     = 1'b1;
        o_sp_dec = 1'b1;
        o_set_b  = 1'b1;
        o_b_brk  = (kind_q == KIND_BRK);
      end
      ST_VEC_LO: begin
        o_busy   = 1'b1;
        o_addr   = vec_base;
        o_set_i  = 1'b1;
        o_i_intr = 1'b1;
      end
      ST_VEC_HI: begin
        o_busy = 1'b1;
        o_addr = vec_base + 16'd1;
      end
      ST_LOAD: begin
        o_busy    = 1'b1;
        o_pc_load = 1'b1;
        o_pc      = {i_rdata, vec_lo_q};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_interrupt_sequencer.sv
module tb_interrupt_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_boundary, i_irq, i_nmi, i_brk;
  logic [7:0]  i_psr, i_sp, i_rdata;
  logic [15:0] i_pc;
  logic [15:0] o_addr, o_pc;
  logic [7:0]  o_wdata;
  logic        o_we, o_sp_dec, o_set_i, o_i_intr, o_set_b, o_b_brk, o_pc_load, o_busy;

  always #5 clk = ~clk;

  interrupt_sequencer dut (
    .clk(clk), .rst(rst), .i_boundary(i_boundary), .i_irq(i_irq), .i_nmi(i_nmi),
    .i_brk(i_brk), .i_psr(i_psr), .i_pc(i_pc), .i_sp(i_sp), .i_rdata(i_rdata),
    .o_addr(o_addr), .o_wdata(o_wdata), .o_we(o_we), .o_sp_dec(o_sp_dec),
    .o_set_i(o_set_i), .o_i_intr(o_i_intr), .o_set_b(o_set_b), .o_b_brk(o_b_brk),
    .o_pc_load(o_pc_load), .o_pc(o_pc), .o_busy(o_busy)
  );

  typedef struct packed {
    logic        busy;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        we, sp_dec, set_i, i_intr, set_b, b_brk, pc_load;
    logic [15:0] pc;
  } out_t;

  typedef struct packed {
    logic [15:0] a;
    logic [7:0]  d;
  } wr_t;

  // Reference model: a script of expected per-cycle outputs queued on acceptance.
  out_t        exp_q[$];
  wr_t         wlog[$];
  bit          m_pend, m_prev;
  logic [15:0] last_addr;
  logic [7:0]  vt[8];
  int          vec_cnt = 0;
  int          miscmp  = 0;

  // Mock memory: vector page from the table, elsewhere an address hash.
  function automatic logic [7:0] mem(input logic [15:0] a);
    if (a[15:3] == 13'h1FFF) return vt[a[2:0]];
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic out_t observed();
    out_t o;
    o.busy = o_busy; o.addr = o_addr; o.wdata = o_wdata; o.we = o_we;
    o.sp_dec = o_sp_dec; o.set_i = o_set_i; o.i_intr = o_i_intr;
    o.set_b = o_set_b; o.b_brk = o_b_brk; o.pc_load = o_pc_load; o.pc = o_pc;
    return o;
  endfunction

  task automatic check_out(input string tag, input out_t o, input out_t e);
    vec_cnt++;
    assert (o === e) else begin
      miscmp++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic check_val(input string tag, input logic [31:0] o, input logic [31:0] e);
    vec_cnt++;
    assert (o === e) else begin
      miscmp++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  // kind: 0 = IRQ, 1 = BRK, 2 = NMI. Core inputs are held while busy.
  task automatic build(input int kind);
    out_t r;
    logic [15:0] v;
    logic [7:0]  p;
    v = (kind == 2) ? 16'hFFFA : 16'hFFFE;
    p = i_psr; p[5] = 1'b1; p[4] = (kind == 1);
    r = '0; r.busy = 1'b1; r.we = 1'b1; r.sp_dec = 1'b1;
    r.addr = {8'h01, i_sp};         r.wdata = i_pc[15:8]; exp_q.push_back(r);
    r.addr = {8'h01, i_sp - 8'd1};  r.wdata = i_pc[7:0];  exp_q.push_back(r);
    r.addr = {8'h01, i_sp - 8'd2};  r.wdata = p;
    r.set_b = 1'b1; r.b_brk = (kind == 1);                exp_q.push_back(r);
    r = '0; r.busy = 1'b1; r.addr = v; r.set_i = 1'b1; r.i_intr = 1'b1; exp_q.push_back(r);
    r = '0; r.busy = 1'b1; r.addr = v + 16'd1;                           exp_q.push_back(r);
    r = '0; r.busy = 1'b1; r.pc_load = 1'b1; r.pc = {mem(v + 16'd1), mem(v)}; exp_q.push_back(r);
  endtask

  // One clock cycle: drive, check at negedge, advance model, step past posedge.
  task automatic cyc(input logic b, input logic irq, input logic nmi, input logic brk);
    out_t e;
    bit   was_idle;
    i_boundary = b; i_irq = irq; i_nmi = nmi; i_brk = brk;
    i_rdata = mem(last_addr);
    @(negedge clk);
    was_idle = (exp_q.size() == 0);
    e = '0;
    if (!was_idle) e = exp_q.pop_front();
    check_out($sformatf("outputs@%0t", $time), observed(), e);
    check_val($sformatf("nmi_pend@%0t", $time), {31'd0, dut.nmi_pend}, {31'd0, m_pend});
    if (o_we) wlog.push_back({o_addr, o_wdata});
    last_addr = o_addr;
    if (was_idle && b) begin
      if (m_pend) begin build(2); m_pend = 1'b0; end
      else if (brk) build(1);
      else if (irq && !i_psr[2]) build(0);
    end
    if (nmi && !m_prev) m_pend = 1'b1;
    m_prev = nmi;
    @(posedge clk); #1;
    if (e.sp_dec) i_sp = i_sp - 8'd1;
  endtask

  task automatic check_writes(input string tag, input wr_t w0, input wr_t w1, input wr_t w2);
    wr_t ew[3];
    wr_t got;
    ew[0] = w0; ew[1] = w1; ew[2] = w2;
    check_val({tag, "_count"}, wlog.size(), 32'd3);
    for (int i = 0; i < 3; i++) begin
      got = (i < wlog.size()) ? wlog[i] : '0;
      check_val($sformatf("%s_wr%0d", tag, i), {8'd0, got}, {8'd0, ew[i]});
    end
  endtask

  initial begin
    rst = 1'b1;
    i_boundary = 0; i_irq = 0; i_nmi = 0; i_brk = 0;
    i_psr = 8'h00; i_pc = 16'h0000; i_sp = 8'hFF; i_rdata = 8'h00;
    m_pend = 0; m_prev = 0; last_addr = 16'h0000;
    vt[0] = 8'h01; vt[1] = 8'h02; vt[2] = 8'h00; vt[3] = 8'hC0;
    vt[4] = 8'h05; vt[5] = 8'h06; vt[6] = 8'h00; vt[7] = 8'h80;

    #1;
    check_out("reset_outputs", observed(), '0);
    check_val("reset_nmi_pend", {31'd0, dut.nmi_pend}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // IRQ with I clear: pushes 12/34/20 down from 01FD, vector FFFE -> 8000.
    i_pc = 16'h1234; i_sp = 8'hFD; i_psr = 8'h20; wlog.delete();
    cyc(1, 1, 0, 0);
    repeat (6) cyc(0, 0, 0, 0);
    check_writes("irq", {16'h01FD, 8'h12}, {16'h01FC, 8'h34}, {16'h01FB, 8'h20});

    // BRK with P=00: pushed P has B and U set.
    i_pc = 16'hA55A; i_sp = 8'h80; i_psr = 8'h00; wlog.delete();
    cyc(1, 0, 0, 1);
    repeat (6) cyc(0, 0, 0, 0);
    check_writes("brk", {16'h0180, 8'hA5}, {16'h017F, 8'h5A}, {16'h017E, 8'h30});

    // Masked IRQ: no sequence.
    i_psr = 8'h04;
    repeat (3) cyc(1, 1, 0, 0);
    check_val("masked_irq_busy", {31'd0, o_busy}, 32'd0);

    // NMI beats BRK and IRQ; edge during the sequence queues a second NMI.
    i_psr = 8'h00; i_pc = 16'h4000; i_sp = 8'hF0;
    cyc(0, 0, 1, 0);
    cyc(1, 1, 1, 1);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0);
    repeat (4) cyc(1, 1, 1, 1);
    cyc(1, 0, 1, 0);
    repeat (6) cyc(0, 0, 1, 0);

    // Edge in the same cycle as NMI acceptance stays pending.
    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);
    cyc(1, 0, 1, 0);
    repeat (6) cyc(0, 0, 1, 0);
    cyc(1, 0, 1, 0);
    repeat (6) cyc(0, 0, 0, 0);

    // Reset in VEC_LO with an NMI pending: abort at once.
    i_psr = 8'h00;
    cyc(1, 1, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    check_val("pre_reset_set_i", {31'd0, o_set_i}, 32'd1);
    i_nmi = 1'b0; i_boundary = 0; i_irq = 0; i_brk = 0;
    #2 rst = 1'b1;
    #1;
    check_out("midseq_reset_outputs", observed(), '0);
    check_val("midseq_reset_nmi_pend", {31'd0, dut.nmi_pend}, 32'd0);
    exp_q.delete(); m_pend = 0; m_prev = 0; last_addr = 16'h0000;
    @(posedge clk); #1;
    check_out("reset_held_outputs", observed(), '0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Randomized traffic against the script model.
    for (int i = 0; i < 8; i++) vt[i] = 8'($urandom);
    for (int n = 0; n < 600; n++) begin
      logic nmi_n;
      if (exp_q.size() == 0) begin
        i_pc = 16'($urandom); i_psr = 8'($urandom); i_sp = 8'($urandom);
      end
      nmi_n = ($urandom_range(0, 7) == 0) ? ~i_nmi : i_nmi;
      cyc(1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 3), nmi_n,
          ($urandom_range(0, 9) < 2));
    end
    repeat (7) cyc(0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
    $finish;
  end

endmodule

// File: doc/interrupt_sequencer.md
INTERRUPT_SEQUENCER -- requirements
Module: interrupt_sequencer

Interface
REQ-001 SHALL: clk  in  1  single clock; all state changes on rising edge.
REQ-002 SHALL: rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL: i_boundary  in  1  core at instruction boundary; sequence may start this cycle.
REQ-004 SHALL: i_irq  in  1  maskable interrupt, level-sensitive, active-high.
REQ-005 SHALL: i_nmi  in  1  non-maskable interrupt, rising-edge-sensitive.
REQ-006 SHALL: i_brk  in  1  decoder flags BRK opcode, qualified by i_boundary.
REQ-007 SHALL: i_psr  in  8  current status register value; bit2 = I.
REQ-008 SHALL: i_pc  in  16  return address to push, already adjusted by core.
REQ-009 SHALL: i_sp  in  8  current stack pointer.
REQ-010 SHALL: i_rdata  in  8  memory read data, valid one cycle after address.
REQ-011 SHALL: o_addr / o_wdata / o_we  out  16/8/1  memory address, write data, write strobe.
REQ-012 SHALL: o_sp_dec  out  1  one-cycle stack-pointer decrement pulse.
REQ-013 SHALL: o_set_i, o_i_intr, o_set_b, o_b_brk  out  1 each  status-register flag controls.
REQ-014 SHALL: o_pc_load  out  1; o_pc  out  16  one-cycle PC load with vector.
REQ-015 SHALL: o_busy  out  1  high in every non-IDLE state; core stalls while high.

Function
REQ-016 SHALL: rising i_nmi edge (sampled vs. previous-cycle value) sets nmi_pend; nmi_pend clears only when an NMI sequence is accepted.
REQ-017 SHALL: acceptance in IDLE with i_boundary=1 uses priority NMI (nmi_pend) > BRK (i_brk) > IRQ (i_irq & ~i_psr[2]); none qualifies -> stay IDLE.
REQ-018 SHALL: NMI edge in same cycle as NMI acceptance stays pending (second sequence follows).
REQ-019 SHALL: state sequence IDLE -> PUSH_PCH -> PUSH_PCL -> PUSH_P -> VEC_LO -> VEC_HI -> LOAD -> IDLE, one cycle each; accept at cycle N, o_pc_load at N+6.
REQ-020 SHALL: push states drive o_addr={8'h01,i_sp}, o_we=1, o_sp_dec=1; data i_pc[15:8], i_pc[7:0], then P.
REQ-021 SHALL: pushed P = i_psr with bit5=1 and bit4=1 for BRK, 0 for IRQ/NMI.
REQ-022 SHALL: in PUSH_P pulse o_set_b=1, o_b_brk=1 for BRK else 0.
REQ-023 SHALL: in VEC_LO drive vector low address (NMI 16'hFFFA, IRQ/BRK 16'hFFFE), o_we=0, pulse o_set_i=1 with o_i_intr=1.
REQ-024 SHALL: in VEC_HI capture i_rdata as vector low byte, drive vector+1.
REQ-025 SHALL: in LOAD pulse o_pc_load, o_pc={i_rdata, captured low byte}.
REQ-026 SHALL: IRQ/BRK/NMI requests arriving while busy are ignored except NMI edges, which latch per REQ-016.
REQ-027 SHALL: outside active cycles, o_we, o_sp_dec, o_set_*, o_pc_load = 0; o_addr, o_wdata, o_pc = 0 in IDLE.

Reset
REQ-028 SHALL: rst asserted -> immediately state IDLE, nmi_pend=0, nmi edge history=0, vector low byte=0, all outputs 0.
REQ-029 SHALL: rst mid-sequence aborts without further writes; first post-reset edge requires a fresh i_nmi 0->1.

Structure
REQ-030 SHALL: shared package holds state encoding, vector addresses (FFFA/FFFE), stack page 8'h01, PSR bit indices (I=2, B=4, U=5).
REQ-031 SHALL: NMI edge detect + pending latch is a sub-module nmi_edge_latch; rest is one FSM.

Verification
REQ-032 SHALL: IRQ=1, I=0, i_pc=16'h1234, i_sp=8'hFD, i_psr=8'h20 -> writes 12@01FD, 34@01FC, 20@01FB (sp mocked), I set, reads FFFE/FFFF, o_pc loaded N+6.
REQ-033 SHALL: BRK at boundary, i_psr=8'h00 -> pushed P=8'h30, o_b_brk=1 in PUSH_P, vector FFFE.
REQ-034 SHALL: IRQ=1 with i_psr[2]=1 -> no sequence, o_busy stays 0.
REQ-035 SHALL: NMI edge + IRQ + BRK same boundary -> NMI vector FFFA; second NMI edge during sequence -> second NMI sequence on next boundary.
REQ-036 SHALL: rst asserted in VEC_LO -> o_busy=0, no o_pc_load, nmi_pend=0 same cycle.
